mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit for the EX stage, parametrised in WIDTH. It computes

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mult_div_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage types for the iterative multiply/divide unit.
package mips_pkg;

  // Operation codes accepted by the multiply/divide unit
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  // Sequencer states of the multiply/divide unit
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit writing the architectural HI/LO pair.
// Signed operands are reduced to magnitudes in PREP, WIDTH shift-add or
// restoring shift-subtract steps run in CALC, and FIX restores the signs.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_t         r_state;
  mdu_state_t         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_signed;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;     // accumulator (mult) / partial remainder (div)
  logic [WIDTH-1:0]   r_low;     // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0]   r_opnd;    // multiplicand / divisor magnitude
  logic               r_neg_lo;  // product or quotient must be negated
  logic               r_neg_hi;  // remainder must be negated
  logic               r_bzero;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_md;
  logic               w_is_div;
  logic               w_is_sgn;
  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_x;
  logic [WIDTH:0]     w_y;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_accept  = start & ~cancel & (r_state == IDLE);
  assign busy      = r_busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign divByZero = r_dbz;

  // Decode the incoming opcode into iterative-op class, divide and signedness
  always_comb begin
    w_is_md  = 1'b0;
    w_is_div = 1'b0;
    w_is_sgn = 1'b0;
    case (op)
      MDU_MULT:  begin w_is_md = 1'b1; w_is_sgn = 1'b1; end
      MDU_MULTU: begin w_is_md = 1'b1; end
      MDU_DIV:   begin w_is_md = 1'b1; w_is_div = 1'b1; w_is_sgn = 1'b1; end
      MDU_DIVU:  begin w_is_md = 1'b1; w_is_div = 1'b1; end
      default:   begin w_is_md = 1'b0; end
    endcase
  end

  // Operand magnitudes and sign bookkeeping used when entering CALC
  always_comb begin
    w_a_neg = r_signed & r_a[WIDTH-1];
    w_b_neg = r_signed & r_b[WIDTH-1];
    w_a_mag = w_a_neg ? -r_a : r_a;
    w_b_mag = w_b_neg ? -r_b : r_b;
  end

  // Shared WIDTH+1-bit adder: add multiplicand, or subtract divisor from shifted remainder
  always_comb begin
    w_shift = {r_acc, r_low[WIDTH-1]};
    if (r_is_div) begin
      w_x   = w_shift;
      w_y   = ~{1'b0, r_opnd};
      w_cin = 1'b1;
    end else begin
      w_x   = {1'b0, r_acc};
      w_y   = r_low[0] ? {1'b0, r_opnd} : {(WIDTH + 1){1'b0}};
      w_cin = 1'b0;
    end
    w_sum  = w_x + w_y + (WIDTH + 1)'(w_cin);
    // remainder stays below the divisor, so the top bit is the borrow
    w_qbit = ~w_sum[WIDTH];
  end

  // Sign restoration applied when the result is committed
  always_comb begin
    w_mag  = {r_acc, r_low};
    w_prod = r_neg_lo ? -w_mag : w_mag;
    w_quo  = r_neg_lo ? -r_low : r_low;
    w_rem  = r_neg_hi ? -r_acc : r_acc;
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next-state: a flush returns to IDLE from any active state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_md) w_state_nxt = PREP;
        else                     w_state_nxt = IDLE;
      end
      PREP: begin
        if (cancel) w_state_nxt = IDLE;
        else        w_state_nxt = CALC;
      end
      CALC: begin
        if (cancel)                               w_state_nxt = IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))      w_state_nxt = FIX;
        else                                      w_state_nxt = CALC;
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_low    <= '0;
      r_opnd   <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_bzero  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_is_md) begin
            r_a      <= a;
            r_b      <= b;
            r_is_div <= w_is_div;
            r_signed <= w_is_sgn;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b1;
          end else if (w_accept && (op == MDU_MTHI)) begin
            r_hi   <= a;
            r_done <= 1'b1;
          end else if (w_accept && (op == MDU_MTLO)) begin
            r_lo   <= a;
            r_done <= 1'b1;
          end
        end
        PREP: begin
          if (cancel) begin
            r_busy <= 1'b0;
            r_dbz  <= 1'b0;
          end else begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_bzero  <= r_is_div & (r_b == '0);
            if (r_is_div) begin
              r_low  <= w_a_mag;
              r_opnd <= w_b_mag;
            end else begin
              r_low  <= w_b_mag;
              r_opnd <= w_a_mag;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            r_busy <= 1'b0;
            r_dbz  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
              r_acc <= w_qbit ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
              r_low <= {r_low[WIDTH-2:0], w_qbit};
            end else begin
              r_acc <= w_sum[WIDTH:1];
              r_low <= {w_sum[0], r_low[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          if (cancel) begin
            r_busy <= 1'b0;
            r_dbz  <= 1'b0;
          end else begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_dbz  <= r_bzero;
            if (!r_is_div) begin
              {r_hi, r_lo} <= w_prod;
            end else if (r_bzero) begin
              r_hi <= r_a;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: directed corner cases plus randomized ops on a
// 32-bit and an 8-bit instance, compared against an arithmetic model.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  // 32-bit instance
  logic        s_start = 1'b0, s_cancel = 1'b0;
  logic [2:0]  s_op = 3'd0;
  logic [31:0] s_a = 32'd0, s_b = 32'd0;
  logic        s_busy, s_done, s_dbz;
  logic [31:0] s_hi, s_lo;
  // 8-bit instance
  logic        t_start = 1'b0, t_cancel = 1'b0;
  logic [2:0]  t_op = 3'd0;
  logic [7:0]  t_a = 8'd0, t_b = 8'd0;
  logic        t_busy, t_done, t_dbz;
  logic [7:0]  t_hi, t_lo;

  int n_assert = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
    .cancel(s_cancel), .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo),
    .divByZero(s_dbz));

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(t_start), .op(t_op), .a(t_a), .b(t_b),
    .cancel(t_cancel), .busy(t_busy), .done(t_done), .hi(t_hi), .lo(t_lo),
    .divByZero(t_dbz));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands
  function automatic void model(input int w, input logic [2:0] o, input logic [31:0] av,
                                input logic [31:0] bv, output logic [31:0] eh,
                                output logic [31:0] el, output logic ed);
    logic [63:0] mask, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
    sb = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
    ed = 1'b0;
    p  = 64'd0;
    if (o == MDU_MULT) p = sa * sb;
    else if (o == MDU_MULTU) p = {32'd0, av} * {32'd0, bv};
    else if (bv == 32'd0) begin
      p  = ({32'd0, av} << w) | mask;
      ed = 1'b1;
    end else begin
      if (o == MDU_DIV) begin q = sa / sb; r = sa % sb; end
      else begin q = longint'(av) / longint'(bv); r = longint'(av) % longint'(bv); end
      p = ((r & mask) << w) | (q & mask);
    end
    eh = 32'((p >> w) & mask);
    el = 32'(p & mask);
  endfunction

  task automatic drive(input int w, input logic st, input logic [2:0] o,
                       input logic [31:0] av, input logic [31:0] bv);
    if (w == 32) begin s_start = st; s_op = o; s_a = av; s_b = bv; end
    else begin t_start = st; t_op = o; t_a = av[7:0]; t_b = bv[7:0]; end
  endtask

  function automatic logic g_done(input int w); return (w == 32) ? s_done : t_done; endfunction
  function automatic logic g_busy(input int w); return (w == 32) ? s_busy : t_busy; endfunction
  function automatic logic g_dbz(input int w);  return (w == 32) ? s_dbz  : t_dbz;  endfunction
  function automatic logic [31:0] g_hi(input int w); return (w == 32) ? s_hi : {24'd0, t_hi}; endfunction
  function automatic logic [31:0] g_lo(input int w); return (w == 32) ? s_lo : {24'd0, t_lo}; endfunction

  // Launch one iterative op and check latency, busy, done and result.
  // b2b: start is driven in the current (done) cycle without waiting.
  // pester: hammer start with a DIVU by zero while the op is in flight.
  task automatic run_op(input int w, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input bit b2b, input bit pester,
                        input string tag);
    logic [31:0] eh, el;
    logic        ed;
    int          n;
    model(w, o, av, bv, eh, el, ed);
    if (!b2b) @(negedge clk);
    drive(w, 1'b1, o, av, bv);
    @(negedge clk);
    drive(w, pester, pester ? 3'(MDU_DIVU) : o, pester ? 32'd100 : av, 32'd0);
    check({tag, "_busy"}, 64'(g_busy(w)), 64'd1);
    check({tag, "_done_lo"}, 64'(g_done(w)), 64'd0);
    n = 0;
    while (!g_done(w) && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 5) drive(w, 1'b0, o, av, bv);
    end
    drive(w, 1'b0, o, av, bv);
    check({tag, "_latency"}, 64'(n), 64'(w + 2));
    check({tag, "_hi"}, 64'(g_hi(w)), 64'(eh));
    check({tag, "_lo"}, 64'(g_lo(w)), 64'(el));
    check({tag, "_dbz"}, 64'(g_dbz(w)), 64'(ed));
    check({tag, "_busy_end"}, 64'(g_busy(w)), 64'd0);
  endtask

  initial begin
    logic [31:0] hold_hi, hold_lo, ra, rb;
    logic [2:0]  ro;
    int          seen;

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_done", 64'(s_done), 64'd0);
    check("rst_hi", 64'(s_hi), 64'd0);
    check("rst_lo", 64'(s_lo), 64'd0);
    check("rst_dbz", 64'(s_dbz), 64'd0);
    rst_n = 1'b1;

    // directed vectors
    run_op(32, MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "multu_max");
    check("multu_max_hi_k", 64'(s_hi), 64'hFFFFFFFE);
    check("multu_max_lo_k", 64'(s_lo), 64'h00000001);
    run_op(32, MDU_MULT, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, "mult_neg_b2b");
    check("mult_neg_lo_k", 64'(s_lo), 64'hFFFFFFF1);
    run_op(32, MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div_neg");
    check("div_neg_lo_k", 64'(s_lo), 64'hFFFFFFFD);
    check("div_neg_hi_k", 64'(s_hi), 64'hFFFFFFFF);
    run_op(32, MDU_DIVU, 32'h00001234, 32'd0, 1'b0, 1'b0, "divu_zero");
    check("divu_zero_lo_k", 64'(s_lo), 64'hFFFFFFFF);
    check("divu_zero_dbz_k", 64'(s_dbz), 64'd1);
    run_op(32, MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_ovf");
    check("div_ovf_lo_k", 64'(s_lo), 64'h80000000);
    check("div_ovf_hi_k", 64'(s_hi), 64'd0);
    run_op(32, MDU_MULTU, 32'd3, 32'd4, 1'b0, 1'b1, "busy_start_ignored");
    run_op(8, MDU_DIVU, 32'd200, 32'd7, 1'b0, 1'b0, "w8_divu");
    check("w8_divu_lo_k", 64'(t_lo), 64'd28);
    check("w8_divu_hi_k", 64'(t_hi), 64'd4);

    // MTHI / MTLO
    @(negedge clk);
    drive(32, 1'b1, MDU_MTHI, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    drive(32, 1'b0, MDU_MTHI, 32'hDEADBEEF, 32'd0);
    check("mthi_hi", 64'(s_hi), 64'hDEADBEEF);
    check("mthi_done", 64'(s_done), 64'd1);
    check("mthi_busy", 64'(s_busy), 64'd0);
    drive(32, 1'b1, MDU_MTLO, 32'h01234567, 32'd0);
    @(negedge clk);
    drive(32, 1'b0, MDU_MTLO, 32'd0, 32'd0);
    check("mtlo_lo", 64'(s_lo), 64'h01234567);
    check("mtlo_hi_kept", 64'(s_hi), 64'hDEADBEEF);
    @(negedge clk);
    check("mt_done_pulse", 64'(s_done), 64'd0);

    // start together with cancel in IDLE is ignored; illegal opcode is ignored
    s_cancel = 1'b1;
    drive(32, 1'b1, MDU_MTHI, 32'h11111111, 32'd0);
    @(negedge clk);
    s_cancel = 1'b0;
    drive(32, 1'b1, 3'd7, 32'h22222222, 32'd3);
    @(negedge clk);
    drive(32, 1'b0, MDU_MULT, 32'd0, 32'd0);
    check("cancel_start_hi", 64'(s_hi), 64'hDEADBEEF);
    check("illegal_busy", 64'(s_busy), 64'd0);
    check("illegal_done", 64'(s_done), 64'd0);

    // cancel in CALC: no result, no done
    hold_hi = s_hi;
    hold_lo = s_lo;
    drive(32, 1'b1, MDU_MULT, 32'd7, 32'd9);
    @(negedge clk);
    drive(32, 1'b0, MDU_MULT, 32'd7, 32'd9);
    repeat (11) @(negedge clk);
    check("cancel_busy_before", 64'(s_busy), 64'd1);
    s_cancel = 1'b1;
    @(negedge clk);
    s_cancel = 1'b0;
    check("cancel_busy", 64'(s_busy), 64'd0);
    check("cancel_hi", 64'(s_hi), 64'(hold_hi));
    check("cancel_lo", 64'(s_lo), 64'(hold_lo));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_done) seen++;
    end
    check("cancel_no_done", 64'(seen), 64'd0);

    // reset mid-CALC clears everything at once
    drive(32, 1'b1, MDU_DIVU, 32'd1000, 32'd3);
    @(negedge clk);
    drive(32, 1'b0, MDU_DIVU, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", 64'(s_busy), 64'd0);
    check("rstmid_hi", 64'(s_hi), 64'd0);
    check("rstmid_lo", 64'(s_lo), 64'd0);
    check("rstmid_done", 64'(s_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // random, 32-bit
    for (int i = 0; i < 100; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
      run_op(32, ro, ra, rb, bit'($urandom_range(0, 1)), 1'b0, "rnd32");
    end

    // random, 8-bit
    for (int i = 0; i < 1000; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      run_op(8, ro, ra, rb, bit'($urandom_range(0, 1)), 1'b0, "rnd8");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
